// File: rtl/vram_arb_pkg.sv
// Purpose: shared types and default widths for the video RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vram_arb_pkg;

    localparam int ARB_ADDR_W    = 18;
    localparam int ARB_DATA_W    = 16;
    localparam int ARB_BURST_LEN = 8;
    localparam int ARB_CPU_ADR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_VID     = 3'd1,
        ST_CPU_RD  = 3'd2,
        ST_CPU_RDW = 3'd3,
        ST_CPU_WR  = 3'd4,
        ST_CPU_ACK = 3'd5
    } arb_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Purpose: shares one synchronous SRAM between video read bursts and single-word CPU accesses.
// Latency: vid_ack 1 cycle after grant, vid data 2..BURST_LEN+1; CPU read ack grant+3, write ack grant+2.
// Backpressure: level req held until ack; video wins ties, but the CPU always gets the slot after a burst.
// Ports: clk_i/rst_i; vid_req/vid_adr/vid_ack/vid_valid/vid_dat burst port;
//        cpu_req/cpu_we/cpu_adr/cpu_dat_i/cpu_dat_o/cpu_ack word port; sram_* device pins.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int BURST_LEN = ARB_BURST_LEN,
    parameter logic [ADDR_W-ARB_CPU_ADR_W-1:0] CPU_PAGE = 2'b11
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     vid_req,
    input  logic [ADDR_W-1:0]        vid_adr,
    output logic                     vid_ack,
    output logic                     vid_valid,
    output logic [DATA_W-1:0]        vid_dat,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ARB_CPU_ADR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0]        cpu_dat_i,
    output logic [DATA_W-1:0]        cpu_dat_o,
    output logic                     cpu_ack,
    output logic [ADDR_W-1:0]        sram_adr,
    output logic                     sram_oe,
    output logic                     sram_we,
    output logic [DATA_W-1:0]        sram_dat_o,
    input  logic [DATA_W-1:0]        sram_dat_i
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    arb_state_t               state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [ADDR_W-1:0]        vid_base, vid_base_nxt;
    logic [ARB_CPU_ADR_W-1:0] cpu_adr_q, cpu_adr_nxt;
    logic [DATA_W-1:0]        cpu_wdat_q, cpu_wdat_nxt;
    logic                     grant_vid;
    logic                     grant_cpu;

    // State, burst counter and all acknowledge outputs are registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            vid_base   <= '0;
            cpu_adr_q  <= '0;
            cpu_wdat_q <= '0;
            vid_ack    <= 1'b0;
            vid_valid  <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_dat_o  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            vid_base   <= vid_base_nxt;
            cpu_adr_q  <= cpu_adr_nxt;
            cpu_wdat_q <= cpu_wdat_nxt;
            vid_ack    <= grant_vid;
            // SRAM returns data one cycle after the strobe, so valid trails the video strobe by one.
            vid_valid  <= (state == ST_VID);
            cpu_ack    <= (state == ST_CPU_RDW) || (state == ST_CPU_WR);
            if (state == ST_CPU_RDW) begin
                cpu_dat_o <= sram_dat_i;
            end
        end
    end

    // Requests are only looked at in IDLE and on the last word of a burst; the CPU
    // beats a pending video request at the burst boundary so it cannot starve.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        vid_base_nxt = vid_base;
        cpu_adr_nxt  = cpu_adr_q;
        cpu_wdat_nxt = cpu_wdat_q;
        grant_vid    = 1'b0;
        grant_cpu    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (vid_req) begin
                    grant_vid = 1'b1;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                end
            end
            ST_VID: begin
                if (cnt == CNT_LAST) begin
                    if (cpu_req) begin
                        grant_cpu = 1'b1;
                    end else if (vid_req) begin
                        grant_vid = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_CPU_RD:  state_nxt = ST_CPU_RDW;
            ST_CPU_RDW: state_nxt = ST_CPU_ACK;
            ST_CPU_WR:  state_nxt = ST_CPU_ACK;
            // cpu_req is deliberately not sampled here: it is still high during the ack cycle.
            ST_CPU_ACK: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase

        if (grant_vid) begin
            state_nxt    = ST_VID;
            cnt_nxt      = '0;
            vid_base_nxt = vid_adr;
        end
        if (grant_cpu) begin
            state_nxt    = cpu_we ? ST_CPU_WR : ST_CPU_RD;
            cpu_adr_nxt  = cpu_adr;
            cpu_wdat_nxt = cpu_dat_i;
        end
    end

    // SRAM pins decode from registered state only; the burst address wraps modulo 2^ADDR_W.
    always_comb begin
        sram_adr   = '0;
        sram_oe    = 1'b0;
        sram_we    = 1'b0;
        sram_dat_o = '0;
        case (state)
            ST_VID: begin
                sram_adr = vid_base + {{(ADDR_W-CNT_W){1'b0}}, cnt};
                sram_oe  = 1'b1;
            end
            ST_CPU_RD: begin
                sram_adr = {CPU_PAGE, cpu_adr_q};
                sram_oe  = 1'b1;
            end
            ST_CPU_WR: begin
                sram_adr   = {CPU_PAGE, cpu_adr_q};
                sram_we    = 1'b1;
                sram_dat_o = cpu_wdat_q;
            end
            default: begin
                sram_adr = '0;
            end
        endcase
    end

    // Gated so the data bus reads as zero whenever no video word is being delivered.
    assign vid_dat = vid_valid ? sram_dat_i : '0;

endmodule
